// File: rtl/enc_pkg.sv
// Shared helpers and mode constants for the registered request encoder.
package enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Callers zero-extend their request vector to 16 bits.
  function automatic logic popcount_gt1(input logic [15:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 16; i++) cnt += int'(v[i]);
    return cnt > 1;
  endfunction

endpackage

// File: rtl/prio_sel.sv
// Combinational picker: highest set bit (fixed) or first set bit at/above start (round-robin).
module prio_sel #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic [W-1:0] index,
  output logic         any
);

  logic [W-1:0] j;

  always_comb begin
    index = '0;
    j     = '0;
    any   = |req;
    if (!mode) begin
      for (int k = 0; k < N; k++)
        if (req[k]) index = W'(k);
    end else begin
      // Scan downward so the last hit is the one closest above start; W-bit add wraps mod N.
      for (int k = N - 1; k >= 0; k--) begin
        j = start + W'(k);
        if (req[j]) index = j;
      end
    end
  end

endmodule

// File: rtl/enc_rr_reg.sv
// Registered N-to-log2(N) encoder with valid/ready output and fixed or round-robin priority.
module enc_rr_reg
  import enc_pkg::*;
#(
  parameter int N  = 4,
  parameter int RR = 0,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_code,
  output logic [N-1:0] out_onehot,
  output logic         out_multi,
  output logic         busy_drop
);

  logic [W-1:0] ptr;
  logic [W-1:0] idx;
  logic         any;
  logic         cap;
  logic         xfer;

  prio_sel #(.N(N), .W(W)) u_sel (
    .req   (req),
    .start (ptr),
    .mode  (RR == MODE_RR),
    .index (idx),
    .any   (any)
  );

  assign cap  = en & any & (~out_valid | out_ready);
  assign xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_code   <= '0;
      out_onehot <= '0;
      out_multi  <= 1'b0;
      busy_drop  <= 1'b0;
      ptr        <= '0;
    end else begin
      busy_drop <= en & any & out_valid & ~out_ready;
      if (cap) begin
        out_valid  <= 1'b1;
        out_code   <= idx;
        out_onehot <= {{(N-1){1'b0}}, 1'b1} << idx;
        out_multi  <= popcount_gt1(16'(req));
        if (RR == MODE_RR) ptr <= idx + W'(1);
      end else if (xfer) begin
        // Code/onehot are left as-is after a drain; only the flags clear.
        out_valid <= 1'b0;
        out_multi <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enc_rr_reg.sv
// Scoreboard bench: fixed-priority and round-robin encoders share stimulus, each with its own model.
module tb_enc_rr_reg;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] req = '0;
  logic       out_ready = 1'b0;

  logic       ov  [2];
  logic [1:0] oc  [2];
  logic [3:0] ooh [2];
  logic       om  [2];
  logic       ob  [2];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         code;
    logic [3:0] oh;
    logic       multi;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference state
  logic       mv    [2];
  int         mcode [2];
  logic [3:0] moh   [2];
  logic       mmulti[2];
  logic       mbusy [2];
  int         rr_ptr;

  always #5 clk = ~clk;

  enc_rr_reg #(.N(N), .RR(0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
    .out_valid(ov[0]), .out_code(oc[0]), .out_onehot(ooh[0]),
    .out_multi(om[0]), .busy_drop(ob[0])
  );

  enc_rr_reg #(.N(N), .RR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
    .out_valid(ov[1]), .out_code(oc[1]), .out_onehot(ooh[1]),
    .out_multi(om[1]), .busy_drop(ob[1])
  );

  function automatic int pick(input int d, input logic [3:0] r, input int p);
    int res;
    res = -1;
    if (d == 0) begin
      for (int k = N - 1; k >= 0; k--)
        if (res < 0 && r[k]) res = k;
    end else begin
      for (int k = 0; k < N; k++)
        if (res < 0 && r[(p + k) % N]) res = (p + k) % N;
    end
    return res;
  endfunction

  function automatic logic [3:0] dec2to4(input logic [1:0] code, input logic e);
    logic [3:0] r;
    r = '0;
    if (e) r[code] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut=%0d t=%0t actual=%0d required=%0d", name, d, $time, act, exp);
    end
  endtask

  // Behavioural model: advances at each active edge from the inputs the DUT sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mv[d] <= 1'b0; mcode[d] <= 0; moh[d] <= '0; mmulti[d] <= 1'b0; mbusy[d] <= 1'b0;
      end
      rr_ptr <= 0;
      q0.delete();
      q1.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        automatic bit has = (req != 0);
        automatic bit c   = en && has && (!mv[d] || out_ready);
        automatic int sel = pick(d, req, rr_ptr);
        automatic exp_t e;
        mbusy[d] <= en && has && mv[d] && !out_ready;
        if (c) begin
          e.code = sel; e.oh = 4'(1 << sel); e.multi = ($countones(req) > 1);
          if (d == 0) q0.push_back(e); else q1.push_back(e);
          mv[d] <= 1'b1; mcode[d] <= sel; moh[d] <= e.oh; mmulti[d] <= e.multi;
          if (d == 1) rr_ptr <= (sel + 1) % N;
        end else if (mv[d] && out_ready) begin
          mv[d] <= 1'b0; mmulti[d] <= 1'b0;
        end
      end
    end
  end

  // Monitor: compares presented results against the scoreboard, pops on transfer.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk("rst_valid", d, int'(ov[d]), 0);
        chk("rst_code", d, int'(oc[d]), 0);
        chk("rst_onehot", d, int'(ooh[d]), 0);
        chk("rst_busy", d, int'(ob[d]), 0);
      end else begin
        chk("valid", d, int'(ov[d]), int'(mv[d]));
        chk("busy_drop", d, int'(ob[d]), int'(mbusy[d]));
        chk("multi", d, int'(om[d]), int'(mmulti[d]));
        chk("code_hold", d, int'(oc[d]), mcode[d]);
        chk("onehot_hold", d, int'(ooh[d]), int'(moh[d]));
        if (ov[d]) begin
          automatic exp_t e;
          automatic int sz = (d == 0) ? q0.size() : q1.size();
          if (sz == 0) begin
            chk("sb_empty", d, 1, 0);
          end else begin
            e = (d == 0) ? q0[0] : q1[0];
            chk("sb_code", d, int'(oc[d]), e.code);
            chk("sb_onehot", d, int'(ooh[d]), int'(e.oh));
            chk("sb_multi", d, int'(om[d]), int'(e.multi));
            chk("roundtrip", d, int'(dec2to4(oc[d], 1'b1)), int'(ooh[d]));
            if (out_ready) begin
              if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic drive(input logic e, input logic [3:0] r, input logic rd, input int n);
    for (int i = 0; i < n; i++) begin
      en = e; req = r; out_ready = rd;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Single request, then async reset while valid
    drive(1, 4'b0100, 1, 1);
    drive(0, 4'b0000, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_valid", d, int'(ov[d]), 0);
      chk("async_rst_code", d, int'(oc[d]), 0);
      chk("async_rst_onehot", d, int'(ooh[d]), 0);
      chk("async_rst_multi", d, int'(om[d]), 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    // Fixed priority patterns
    drive(1, 4'b1011, 1, 1);
    drive(1, 4'b0011, 1, 1);
    // Round-robin rotation, then wrap
    drive(1, 4'b1111, 1, 5);
    drive(1, 4'b1001, 1, 3);
    // Backpressure with changing request
    drive(1, 4'b0010, 1, 1);
    drive(1, 4'b1000, 0, 3);
    drive(1, 4'b1000, 1, 2);
    // Enable gating and drain
    drive(0, 4'b0010, 1, 3);
    drive(1, 4'b0010, 1, 1);
    drive(1, 4'b0000, 1, 2);
    // Every single-bit request round-trips
    for (int k = 0; k < N; k++) drive(1, 4'(1 << k), 1, 1);
    drive(0, 4'b0000, 1, 1);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      automatic logic [3:0] r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'(1 << $urandom_range(0, 3));
      drive($urandom_range(0, 9) < 8, r, $urandom_range(0, 9) < 7, 1);
    end
    drive(0, 4'b0000, 1, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
